// File: rtl/booth2_pkg.sv
// Shared types and helpers for the Booth-2 sequential multiplier.
// Holds the controller state encoding, the Booth digit encoding and the
// triplet decoder used by the partial-product generator.
package booth2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Radix-4 recoding of one overlapping multiplier triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t decode_triplet(input logic [2:0] t);
    digit_t d;
    case (t)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth2_pp_gen.sv
// Booth-2 partial-product generator (combinational), time-shared by the
// controller. The signed partial product equals pp + neg: negative digits
// are produced as the one's complement of a or 2a with the +1 returned on
// neg, so that -2a for the most negative a (which needs WIDTH+2 bits in
// two's complement) still fits the WIDTH+1-bit pp.
module booth2_pp_gen
  import booth2_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]     triplet,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH:0] pp,
  output logic           neg
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] a_dbl;
  logic [WIDTH:0] sel;

  assign a_ext = {mcand[WIDTH-1], mcand};
  assign a_dbl = {mcand, 1'b0};

  // Select 0, a or 2a from the decoded digit, then invert for negative digits.
  always_comb begin
    sel = '0;
    neg = 1'b0;
    case (decode_triplet(triplet))
      POS1: sel = a_ext;
      POS2: sel = a_dbl;
      NEG1: begin
        sel = a_ext;
        neg = 1'b1;
      end
      NEG2: begin
        sel = a_dbl;
        neg = 1'b1;
      end
      default: sel = '0;
    endcase
    pp = neg ? ~sel : sel;
  end

endmodule

// File: rtl/booth2_seq_mult.sv
// Iterative radix-4 (Booth-2) signed multiplier.
// Accepts a WIDTH x WIDTH operand pair on in_valid/in_ready, walks the
// multiplier one Booth digit per clock through a single shared
// booth2_pp_gen, and returns the 2*WIDTH-bit product on out_valid/out_ready.
// Optional build macro BOOTH_ZERO_SKIP_EN ends RUN early once every
// remaining digit decodes to zero; the product is the same either way.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and product is held stable there until out_ready is seen.
// The FSM state is available as the internal signal 'state' (state_t).
module booth2_seq_mult
  import booth2_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH / 2) + 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(WIDTH / 2 - 1);

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;

  logic [WIDTH:0]       b_ext;
  logic [WIDTH:0]       b_win;
  logic [2:0]           triplet;
  logic [WIDTH:0]       pp;
  logic                 pp_neg;
  logic [2*WIDTH-1:0]   pp_sext;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_next;
  logic [CNT_W:0]       digit_sh;
  logic                 last_digit;
  logic                 run_end;

  // Digit window: b with the implicit b[-1]=0 appended, shifted by 2i.
  assign b_ext    = {b_q, 1'b0};
  assign digit_sh = {cnt, 1'b0};
  assign b_win    = b_ext >> digit_sh;
  assign triplet  = b_win[2:0];

  booth2_pp_gen #(
    .WIDTH(WIDTH)
  ) u_pp_gen (
    .triplet(triplet),
    .mcand  (a_q),
    .pp     (pp),
    .neg    (pp_neg)
  );

  // Sign-extend, weight by 4^i and fold in the deferred +1 of a negative digit.
  assign pp_sext  = {{(WIDTH - 1){pp[WIDTH]}}, pp};
  assign addend   = (pp_sext << digit_sh)
                  + ({{(2 * WIDTH - 1){1'b0}}, pp_neg} << digit_sh);
  assign acc_next = acc + addend;

  assign last_digit = (cnt == LAST_DIGIT);

`ifdef BOOTH_ZERO_SKIP_EN
  // Remaining digits all decode to zero when b[WIDTH-1 : 2i+1] is uniform;
  // an arithmetic shift leaves that slice with copies of its own top bit.
  logic [CNT_W:0]          tail_sh;
  logic signed [WIDTH-1:0] b_tail;
  logic                    tail_zero;

  assign tail_sh   = {cnt, 1'b1};
  assign b_tail    = $signed(b_q) >>> tail_sh;
  assign tail_zero = (b_tail == '0) || (&b_tail);
  assign run_end   = last_digit || tail_zero;
`else
  assign run_end   = last_digit;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    product    = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (run_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        product   = acc;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, digit counter and product accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (state == IDLE && in_valid) begin
      acc <= '0;
      cnt <= '0;
      a_q <= a;
      b_q <= b;
    end else if (state == RUN) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
